// File: rtl/xalu_ise_arb.sv
// Two-port arbiter and result buffer in front of one shared combinational
// xalu_ise datapath. Each accepted op is issued straight to the datapath and
// its result is captured into a per-port response register with valid/ready
// backpressure. Unsupported ops are flagged and accepted ops are counted.
module xalu_ise_arb #(
    parameter bit FAIR  = 1'b1,
    parameter int CNT_W = 16
) (
    input  logic             ise_clk,
    input  logic             ise_rst,

    input  logic             a_val,
    output logic             a_rdy,
    input  logic [4:0]       a_fn,
    input  logic [6:0]       a_imm,
    input  logic [31:0]      a_in1,
    input  logic [31:0]      a_in2,
    output logic             a_rsp_val,
    input  logic             a_rsp_rdy,
    output logic [31:0]      a_rsp_out,
    output logic             a_rsp_err,

    input  logic             b_val,
    output logic             b_rdy,
    input  logic [4:0]       b_fn,
    input  logic [6:0]       b_imm,
    input  logic [31:0]      b_in1,
    input  logic [31:0]      b_in2,
    output logic             b_rsp_val,
    input  logic             b_rsp_rdy,
    output logic [31:0]      b_rsp_out,
    output logic             b_rsp_err,

    output logic             alu_val,
    output logic [4:0]       alu_fn,
    output logic [6:0]       alu_imm,
    output logic [31:0]      alu_in1,
    output logic [31:0]      alu_in2,
    input  logic             alu_oval,
    input  logic [31:0]      alu_out,

    output logic [CNT_W-1:0] a_cnt,
    output logic [CNT_W-1:0] b_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic        ptr_b;
    logic        elig_a;
    logic        elig_b;
    logic        grant_a;
    logic        grant_b;
    logic [31:0] cap_out;
    logic        cap_err;

    // A port may take a new op when its response slot is empty or draining now.
    assign elig_a = a_val & (~a_rsp_val | a_rsp_rdy);
    assign elig_b = b_val & (~b_rsp_val | b_rsp_rdy);

    // Grant: an uncontested port always wins; contested goes to the pointer
    // (round-robin) or to A (fixed priority).
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (elig_a && elig_b) begin
            if (FAIR && ptr_b) grant_b = 1'b1;
            else               grant_a = 1'b1;
        end else begin
            grant_a = elig_a;
            grant_b = elig_b;
        end
    end

    assign a_rdy   = grant_a;
    assign b_rdy   = grant_b;
    assign alu_val = grant_a | grant_b;

    // Issue mux; operands are forced to zero when idle to keep the datapath quiet.
    always_comb begin
        alu_fn  = '0;
        alu_imm = '0;
        alu_in1 = '0;
        alu_in2 = '0;
        if (grant_a) begin
            alu_fn  = a_fn;
            alu_imm = a_imm;
            alu_in1 = a_in1;
            alu_in2 = a_in2;
        end else if (grant_b) begin
            alu_fn  = b_fn;
            alu_imm = b_imm;
            alu_in1 = b_in1;
            alu_in2 = b_in2;
        end
    end

    assign cap_out = alu_oval ? alu_out : 32'd0;
    assign cap_err = ~alu_oval;

    // Round-robin pointer: moves only on contention, to the losing port.
    always_ff @(posedge ise_clk or negedge ise_rst) begin
        if (!ise_rst)
            ptr_b <= 1'b0;
        else if (FAIR && elig_a && elig_b)
            ptr_b <= grant_a;
    end

    // Port A response slot: a new grant overrides a same-cycle drain.
    always_ff @(posedge ise_clk or negedge ise_rst) begin
        if (!ise_rst) begin
            a_rsp_val <= 1'b0;
            a_rsp_out <= '0;
            a_rsp_err <= 1'b0;
        end else if (grant_a) begin
            a_rsp_val <= 1'b1;
            a_rsp_out <= cap_out;
            a_rsp_err <= cap_err;
        end else if (a_rsp_val && a_rsp_rdy) begin
            a_rsp_val <= 1'b0;
        end
    end

    // Port B response slot: a new grant overrides a same-cycle drain.
    always_ff @(posedge ise_clk or negedge ise_rst) begin
        if (!ise_rst) begin
            b_rsp_val <= 1'b0;
            b_rsp_out <= '0;
            b_rsp_err <= 1'b0;
        end else if (grant_b) begin
            b_rsp_val <= 1'b1;
            b_rsp_out <= cap_out;
            b_rsp_err <= cap_err;
        end else if (b_rsp_val && b_rsp_rdy) begin
            b_rsp_val <= 1'b0;
        end
    end

    // Saturating accepted-op counters; unsupported ops count too.
    always_ff @(posedge ise_clk or negedge ise_rst) begin
        if (!ise_rst) begin
            a_cnt <= '0;
            b_cnt <= '0;
        end else begin
            if (grant_a && (a_cnt != CNT_MAX)) a_cnt <= a_cnt + 1'b1;
            if (grant_b && (b_cnt != CNT_MAX)) b_cnt <= b_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_xalu_ise_arb.sv
// Bench for xalu_ise_arb: directed scenarios plus random traffic, checked
// against a transaction-level model of the two ports kept in the bench.
module tb_xalu_ise_arb;

    localparam int CNT_W   = 4;
    localparam int CNT_MAX = 15;

    logic             ise_clk;
    logic             ise_rst;
    logic             a_val, a_rdy, a_rsp_val, a_rsp_rdy, a_rsp_err;
    logic [4:0]       a_fn;
    logic [6:0]       a_imm;
    logic [31:0]      a_in1, a_in2, a_rsp_out;
    logic             b_val, b_rdy, b_rsp_val, b_rsp_rdy, b_rsp_err;
    logic [4:0]       b_fn;
    logic [6:0]       b_imm;
    logic [31:0]      b_in1, b_in2, b_rsp_out;
    logic             alu_val, alu_oval;
    logic [4:0]       alu_fn;
    logic [6:0]       alu_imm;
    logic [31:0]      alu_in1, alu_in2, alu_out;
    logic [CNT_W-1:0] a_cnt, b_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: response slot contents, op counts, and who wins a tie.
    bit          m_val [2];
    logic [31:0] m_out [2];
    bit          m_err [2];
    int          m_cnt [2];
    bit          m_turn_b;

    xalu_ise_arb #(.FAIR(1'b1), .CNT_W(CNT_W)) dut (
        .ise_clk(ise_clk), .ise_rst(ise_rst),
        .a_val(a_val), .a_rdy(a_rdy), .a_fn(a_fn), .a_imm(a_imm),
        .a_in1(a_in1), .a_in2(a_in2), .a_rsp_val(a_rsp_val),
        .a_rsp_rdy(a_rsp_rdy), .a_rsp_out(a_rsp_out), .a_rsp_err(a_rsp_err),
        .b_val(b_val), .b_rdy(b_rdy), .b_fn(b_fn), .b_imm(b_imm),
        .b_in1(b_in1), .b_in2(b_in2), .b_rsp_val(b_rsp_val),
        .b_rsp_rdy(b_rsp_rdy), .b_rsp_out(b_rsp_out), .b_rsp_err(b_rsp_err),
        .alu_val(alu_val), .alu_fn(alu_fn), .alu_imm(alu_imm),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_oval(alu_oval),
        .alu_out(alu_out), .a_cnt(a_cnt), .b_cnt(b_cnt)
    );

    // Datapath stub: fn 3 is unsupported; fn/imm fold into the result so the
    // issue mux is visible in the response.
    assign alu_oval = (alu_fn != 5'd3);
    assign alu_out  = alu_in1 ^ alu_in2 ^ {alu_fn, alu_imm, 20'd0};

    initial begin
        ise_clk = 1'b0;
        forever #5 ise_clk = ~ise_clk;
    end

    function automatic logic [31:0] ref_res(input logic [4:0] fn, input logic [6:0] imm,
                                            input logic [31:0] in1, input logic [31:0] in2);
        if (fn == 5'd3) return 32'd0;
        return in1 ^ in2 ^ {fn, imm, 20'd0};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int p = 0; p < 2; p++) begin
            m_val[p] = 1'b0;
            m_out[p] = 32'd0;
            m_err[p] = 1'b0;
            m_cnt[p] = 0;
        end
        m_turn_b = 1'b0;
    endtask

    task automatic model_port(input int p, input bit g, input bit rr, input logic [4:0] fn,
                              input logic [6:0] imm, input logic [31:0] in1, input logic [31:0] in2);
        if (g) begin
            m_val[p] = 1'b1;
            m_out[p] = ref_res(fn, imm, in1, in2);
            m_err[p] = (fn == 5'd3);
            if (m_cnt[p] < CNT_MAX) m_cnt[p]++;
        end else if (m_val[p] && rr) begin
            m_val[p] = 1'b0;
        end
    endtask

    task automatic check_regs();
        chk("a_rsp_val", a_rsp_val, m_val[0]);
        chk("a_rsp_out", a_rsp_out, m_out[0]);
        chk("a_rsp_err", a_rsp_err, m_err[0]);
        chk("a_cnt", a_cnt, m_cnt[0]);
        chk("b_rsp_val", b_rsp_val, m_val[1]);
        chk("b_rsp_out", b_rsp_out, m_out[1]);
        chk("b_rsp_err", b_rsp_err, m_err[1]);
        chk("b_cnt", b_cnt, m_cnt[1]);
    endtask

    // One clock: check the combinational issue against the model at the
    // negedge, advance the model, then check the registered outputs.
    task automatic run_cycle();
        bit ea, eb, ga, gb;
        logic [31:0] e_in1, e_in2;
        logic [4:0]  e_fn;
        logic [6:0]  e_imm;
        @(negedge ise_clk);
        ea = a_val && (!m_val[0] || a_rsp_rdy);
        eb = b_val && (!m_val[1] || b_rsp_rdy);
        ga = ea && (!eb || !m_turn_b);
        gb = eb && !ga;
        e_fn  = ga ? a_fn  : gb ? b_fn  : 5'd0;
        e_imm = ga ? a_imm : gb ? b_imm : 7'd0;
        e_in1 = ga ? a_in1 : gb ? b_in1 : 32'd0;
        e_in2 = ga ? a_in2 : gb ? b_in2 : 32'd0;
        chk("a_rdy", a_rdy, ga);
        chk("b_rdy", b_rdy, gb);
        chk("alu_val", alu_val, ga | gb);
        chk("alu_fn", alu_fn, e_fn);
        chk("alu_imm", alu_imm, e_imm);
        chk("alu_in1", alu_in1, e_in1);
        chk("alu_in2", alu_in2, e_in2);
        model_port(0, ga, a_rsp_rdy, a_fn, a_imm, a_in1, a_in2);
        model_port(1, gb, b_rsp_rdy, b_fn, b_imm, b_in1, b_in2);
        if (ea && eb) m_turn_b = ga;
        @(posedge ise_clk);
        #1;
        check_regs();
    endtask

    task automatic idle_inputs();
        a_val = 0; a_fn = 0; a_imm = 0; a_in1 = 0; a_in2 = 0; a_rsp_rdy = 1;
        b_val = 0; b_fn = 0; b_imm = 0; b_in1 = 0; b_in2 = 0; b_rsp_rdy = 1;
    endtask

    initial begin
        logic [31:0] held;
        int          cnt_before;

        idle_inputs();
        model_reset();
        ise_rst = 1'b0;
        #12;
        check_regs();
        @(posedge ise_clk);
        #1;
        ise_rst = 1'b1;

        // 1: single op on A.
        a_val = 1; a_in1 = 32'hF0F0F0F0; a_in2 = 32'hFF00FF00;
        #1 chk("t1_a_rdy_same_cycle", a_rdy, 1'b1);
        run_cycle();
        chk("t1_a_rsp_out", a_rsp_out, 32'h0FF00FF0);
        chk("t1_a_rsp_val", a_rsp_val, 1'b1);
        chk("t1_a_cnt", a_cnt, 4'd1);

        // 2: both streaming, round-robin alternation starting at A.
        b_val = 1;
        for (int i = 0; i < 6; i++) begin
            a_in1 = $urandom; b_in1 = $urandom; b_imm = 7'($urandom);
            #1;
            chk("t2_a_rdy", a_rdy, (i % 2) == 0);
            chk("t2_b_rdy", b_rdy, (i % 2) == 1);
            chk("t2_alu_val", alu_val, 1'b1);
            run_cycle();
        end
        chk("t2_a_cnt", a_cnt, 4'd4);
        chk("t2_b_cnt", b_cnt, 4'd3);

        // 3: A's response stalled; B keeps full rate; A re-granted on drain.
        a_rsp_rdy = 0;
        a_in1 = 32'h12345678;
        run_cycle();
        held = a_rsp_out;
        for (int i = 0; i < 3; i++) begin
            a_in1 = $urandom; b_in1 = $urandom;
            #1;
            chk("t3_a_blocked", a_rdy, 1'b0);
            chk("t3_b_granted", b_rdy, 1'b1);
            run_cycle();
            chk("t3_a_out_stable", a_rsp_out, held);
        end
        a_rsp_rdy = 1; b_val = 0; a_in1 = 32'hCAFEF00D;
        #1 chk("t3_a_regrant", a_rdy, 1'b1);
        run_cycle();
        chk("t3_a_val_kept", a_rsp_val, 1'b1);

        // 4: unsupported op still counts.
        cnt_before = int'(a_cnt);
        a_fn = 5'd3; a_imm = 7'h55;
        run_cycle();
        chk("t4_err", a_rsp_err, 1'b1);
        chk("t4_out_zero", a_rsp_out, 32'd0);
        chk("t4_cnt_inc", a_cnt, cnt_before + 1);
        a_fn = 0; a_imm = 0;

        // 5: B counter saturation.
        a_val = 0; b_val = 1;
        for (int i = 0; i < 20; i++) begin
            b_in2 = $urandom;
            run_cycle();
        end
        chk("t5_b_sat", b_cnt, 4'd15);

        // 6: reset while both responses pend and B holds the tie-break.
        for (int k = 0; k < 2; k++) begin
            a_val = 1; b_val = 1; a_rsp_rdy = 0; b_rsp_rdy = 0;
            run_cycle();
            run_cycle();
            if (m_turn_b) break;
            a_val = 0; b_val = 0; a_rsp_rdy = 1; b_rsp_rdy = 1;
            run_cycle();
        end
        idle_inputs();
        a_rsp_rdy = 0; b_rsp_rdy = 0;
        #2 ise_rst = 1'b0;
        #1;
        model_reset();
        chk("t6_a_rsp_val_async", a_rsp_val, 1'b0);
        chk("t6_b_rsp_val_async", b_rsp_val, 1'b0);
        chk("t6_a_cnt_async", a_cnt, 4'd0);
        chk("t6_b_cnt_async", b_cnt, 4'd0);
        @(negedge ise_clk);
        ise_rst = 1'b1;
        @(posedge ise_clk);
        #1;
        a_val = 1; b_val = 1; a_rsp_rdy = 1; b_rsp_rdy = 1;
        #1;
        chk("t6_a_first", a_rdy, 1'b1);
        chk("t6_b_waits", b_rdy, 1'b0);
        run_cycle();

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            a_val     = ($urandom_range(0, 3) != 0);
            b_val     = ($urandom_range(0, 3) != 0);
            a_rsp_rdy = ($urandom_range(0, 2) != 0);
            b_rsp_rdy = ($urandom_range(0, 2) != 0);
            a_fn  = ($urandom_range(0, 5) == 0) ? 5'd3 : 5'($urandom);
            b_fn  = ($urandom_range(0, 5) == 0) ? 5'd3 : 5'($urandom);
            a_imm = 7'($urandom); b_imm = 7'($urandom);
            a_in1 = $urandom; a_in2 = $urandom;
            b_in1 = $urandom; b_in2 = $urandom;
            run_cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
